instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set job FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 64, SHALL set max WAIT cycles before abort.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  in  1  SHALL be asynchronous, active-high.
REQ-005 in_valid  in  1  SHALL mark upstream job word valid.
REQ-006 in_ready  out  1  SHALL indicate FIFO can accept (not full).
REQ-007 in_instr/in_x/in_y  in  32 each  SHALL carry instruction and operand pair.
REQ-008 instruction  out  32  SHALL drive the compute stage instruction input.
REQ-009 address  out  3  SHALL drive the compute stage RAM write address.
REQ-010 x0/y0  out  32 each  SHALL drive the compute stage operands.
REQ-011 cpu_reset  out  1  SHALL drive the compute stage PC reset.
REQ-012 issue  out  1  SHALL pulse one cycle when a job is presented.
REQ-013 cpu_done  in  1  SHALL be a one-cycle completion pulse from the compute stage.
REQ-014 cpu_out  in  32  SHALL carry the compute stage result, valid with cpu_done.
REQ-015 res_valid  out  1 / res_data  out  32  SHALL return captured result for one cycle.
REQ-016 err  out  1  SHALL pulse one cycle on timeout abort.

Function
REQ-017 Transfer SHALL occur when in_valid && in_ready; word pushed to FIFO tail.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-019 IDLE -> ISSUE when FIFO non-empty; otherwise stay IDLE.
REQ-020 ISSUE SHALL last exactly one cycle: pop head, register instruction/x0/y0/address, assert issue; -> WAIT.
REQ-021 Outputs instruction/address/x0/y0/cpu_reset SHALL hold stable from ISSUE until next ISSUE.
REQ-022 cpu_reset SHALL be 1 for any job issued with address 0, else 0.
REQ-023 WAIT -> IDLE on cpu_done; res_data <= cpu_out, res_valid=1 next cycle, address counter +1.
REQ-024 Address counter SHALL be 3 bits, wrap 7 -> 0 (job 9 reuses address 0 with cpu_reset=1).
REQ-025 WAIT timer SHALL count cycles in WAIT; at TIMEOUT without cpu_done -> IDLE, err pulse, counter still +1, no res_valid.
REQ-026 cpu_done outside WAIT SHALL be ignored.
REQ-027 Full FIFO: in_ready=0, pushes refused, no data loss; push and pop in the same cycle on a full FIFO SHALL be legal only as pop-then-push (in_ready uses registered count, so full blocks push).
REQ-028 Empty FIFO: IDLE holds, outputs unchanged, issue=0.
REQ-029 Simultaneous push and pop on non-full FIFO SHALL keep count unchanged.
REQ-030 Issue-to-issue latency SHALL be minimum 3 cycles (ISSUE, WAIT>=1, IDLE).

Reset
REQ-031 Reset SHALL force: state IDLE, FIFO empty, address counter 0, timer 0, instruction/x0/y0/res_data 0, address 0, cpu_reset 1, issue/res_valid/err 0, in_ready 0 while reset is asserted, 1 after.
REQ-032 Reset mid-WAIT SHALL abandon the job silently; a late cpu_done after release is ignored.

Structure
REQ-033 Shared package loader_pkg SHALL hold DATA_W=32, ADDR_W=3, state enum {IDLE, ISSUE, WAIT}.
REQ-034 FIFO SHALL be sub-module loader_fifo (DEPTH, width 96, push/pop/full/empty/count); FSM, counters in instr_loader.

Verification
REQ-035 Reset release, push 1 job (instr=0x0000_1210, x=5, y=3), done with cpu_out=8 -> issue at cycle 2, address 0, cpu_reset=1, res_data=8 res_valid 1 cycle.
REQ-036 Push 9 jobs back-to-back -> addresses 0..7,0; cpu_reset=1 only on jobs 1 and 9; in_ready low when 4 queued.
REQ-037 Withhold cpu_done for 64 cycles in WAIT -> err pulse cycle 65, next job address 1, no res_valid.
REQ-038 cpu_done pulsed in IDLE with empty FIFO -> no res_valid, counter unchanged.
REQ-039 Assert reset while in WAIT with 2 queued jobs -> FIFO empty, address 0, cpu_done after release ignored.
REQ-040 Push and pop same cycle with count 2 -> count stays 2, FIFO order preserved.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared widths and FSM state encoding for the instruction loader
package loader_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: power-of-two job queue with registered occupancy count
module loader_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 96
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [PW-1:0] wr, rd;
   logic do_push, do_pop;
   // full is taken from the registered count, so a pop cannot open room for a same-cycle push
   assign full = count == (PW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rd];
   always_ff @(posedge clk)
      if (do_push) mem[wr] <= din;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         wr <= wr + PW'(do_push);
         rd <= rd + PW'(do_pop);
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: queues jobs and feeds them one at a time to the compute stage
module instr_loader
   import loader_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   output logic [DATA_W-1:0] instruction,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] x0,
   output logic [DATA_W-1:0] y0,
   output logic              cpu_reset,
   output logic              issue,
   input  logic              cpu_done,
   input  logic [DATA_W-1:0] cpu_out,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic              err
);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t state;
   logic [ADDR_W-1:0] addr_cnt;
   logic [TW-1:0] timer;
   logic [3*DATA_W-1:0] head;
   logic [$clog2(DEPTH):0] count;
   logic full, empty;
   assign in_ready = !full && !reset;
   assign issue = state == ISSUE;
   loader_fifo #(.DEPTH(DEPTH), .W(3*DATA_W)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(in_valid && in_ready),
      .pop(issue && !empty),
      .din({in_instr, in_x, in_y}),
      .dout(head),
      .full(full),
      .empty(empty),
      .count(count)
   );
   // operands are latched from the FIFO head on entry to ISSUE so they coincide with the issue pulse
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         addr_cnt <= '0;
         timer <= '0;
         instruction <= '0;
         x0 <= '0;
         y0 <= '0;
         address <= '0;
         cpu_reset <= 1'b1;
         res_data <= '0;
         res_valid <= 1'b0;
         err <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE:
               if (count != '0) begin
                  {instruction, x0, y0} <= head;
                  address <= addr_cnt;
                  cpu_reset <= addr_cnt == '0;
                  state <= ISSUE;
               end
            ISSUE: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT:
               if (cpu_done) begin
                  res_data <= cpu_out;
                  res_valid <= 1'b1;
                  addr_cnt <= addr_cnt + ADDR_W'(1);
                  state <= IDLE;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  err <= 1'b1;
                  addr_cnt <= addr_cnt + ADDR_W'(1);
                  state <= IDLE;
               end else
                  timer <= timer + TW'(1);
            default: state <= IDLE;
         endcase
      end
endmodule
